// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback-stage sink of the pipeline. Selects the writeback value from the
//   MEM/WB register (load data or ALU result), commits it into a general
//   purpose register file with r0 hardwired to zero, and serves the two
//   decode-stage read ports. A write in flight is bypassed onto the read ports
//   in the same cycle, so decode never has to stall on a writeback.
//
// Ports
//   clk            pipeline clock, state updates on the rising edge
//   rst            asynchronous active-high reset (array and counter cleared)
//   WB[1:0]        {RegWrite, MemtoReg} from MEM/WB
//   readData       load value from MEM/WB
//   ALUResult      ALU result from MEM/WB
//   writeRegister  destination register index
//   readReg1/2     decode-stage source indices
//   readData1/2    source values (combinational, bypassed)
//   writeData      selected writeback value (combinational, to forwarding)
//   regWriteEn     effective write strobe for this cycle
//   writeCount     committed register writes since reset (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            WB,
  input  logic [DATA_WIDTH-1:0] readData,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  regWriteEn,
  output logic [31:0]           writeCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Flattened view of the register file; entry 0 is a constant zero so the
  // read mux needs no special case for it beyond the explicit check below.
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [31:0]           write_count_reg;

  // Writeback mux runs every cycle regardless of RegWrite: the forwarding
  // unit looks at writeData even when nothing is committed.
  assign writeData  = WB[0] ? readData : ALUResult;
  assign regWriteEn = WB[1] && (writeRegister != '0);

  assign regs[0] = '0;

  // One flop bank per architectural register. The asynchronous clear has to
  // reach every entry, so the file is built from flops rather than RAM.
  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (regWriteEn && (writeRegister == ADDR_WIDTH'(gi))) begin
          entry_reg <= writeData;
        end
      end

      assign regs[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_count_reg <= '0;
    end else if (regWriteEn) begin
      write_count_reg <= write_count_reg + 32'd1;
    end
  end

  assign writeCount = write_count_reg;

  // Read ports: r0 first, then the same-cycle bypass, then the array. The
  // bypass stays live during reset, since regWriteEn is not gated by rst.
  assign readData1 = (readReg1 == '0) ? '0 :
                     (regWriteEn && (readReg1 == writeRegister)) ? writeData :
                     regs[readReg1];

  assign readData2 = (readReg2 == '0) ? '0 :
                     (regWriteEn && (readReg2 == writeRegister)) ? writeData :
                     regs[readReg2];

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Directed scenarios followed by randomized traffic for wb_regfile. A plain
//   array plus a write counter model the architectural state; expected port
//   values are derived from the writeback/bypass rules each cycle.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk;
  logic        clk_run;
  logic        rst;
  logic [1:0]  WB;
  logic [31:0] readData;
  logic [31:0] ALUResult;
  logic [4:0]  writeRegister;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] writeData;
  logic        regWriteEn;
  logic [31:0] writeCount;

  // Reference state
  logic [31:0] model_regs [32];
  logic [31:0] model_count;

  int total = 0;
  int bad   = 0;

  wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .WB           (WB),
    .readData     (readData),
    .ALUResult    (ALUResult),
    .writeRegister(writeRegister),
    .readReg1     (readReg1),
    .readReg2     (readReg2),
    .readData1    (readData1),
    .readData2    (readData2),
    .writeData    (writeData),
    .regWriteEn   (regWriteEn),
    .writeCount   (writeCount)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s val=%08h", tag, got);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_count = '0;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
    WB = wb; readData = rd; ALUResult = alu;
    writeRegister = wr; readReg1 = r1; readReg2 = r2;
  endtask

  function automatic logic [31:0] exp_wdata();
    return WB[0] ? readData : ALUResult;
  endfunction

  function automatic logic exp_en();
    return WB[1] && (writeRegister != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (exp_en() && idx == writeRegister) return exp_wdata();
    return model_regs[idx];
  endfunction

  // Compare every combinational output against the model, before the edge.
  task automatic pre_check(input string tag);
    #1;
    check({tag, ".wdata"}, writeData, exp_wdata());
    check({tag, ".wen"}, {31'd0, regWriteEn}, {31'd0, exp_en()});
    check({tag, ".rd1"}, readData1, exp_read(readReg1));
    check({tag, ".rd2"}, readData2, exp_read(readReg2));
  endtask

  // Advance one edge, update the model from the inputs held across it.
  task automatic commit(input string tag);
    @(posedge clk);
    if (!rst && exp_en()) begin
      model_regs[writeRegister] = exp_wdata();
      model_count = model_count + 32'd1;
    end
    #1;
    check({tag, ".wcount"}, writeCount, model_count);
  endtask

  initial begin
    logic [4:0] wr;
    clk_run = 1'b0;
    rst = 1'b0;
    drive(2'b00, '0, '0, 5'd0, 5'd5, 5'd31);
    clear_model();

    // Reset with the clock stopped
    #2 rst = 1'b1;
    #1;
    check("rst.rd1", readData1, 32'd0);
    check("rst.rd2", readData2, 32'd0);
    check("rst.wcount", writeCount, 32'd0);
    clk_run = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ALU writeback to r31
    drive(2'b10, 32'h0, 32'h0000000B, 5'd31, 5'd31, 5'd1);
    pre_check("alu");
    commit("alu");
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd31, 5'd31);
    pre_check("alu_after");
    check("alu.r31", readData1, 32'h0000000B);
    check("alu.cnt", writeCount, 32'd1);

    // Load writeback with bypass on both ports
    drive(2'b11, 32'h0000000F, 32'h11111111, 5'd7, 5'd7, 5'd7);
    pre_check("ld_byp");
    check("ld.byp1", readData1, 32'h0000000F);
    check("ld.byp2", readData2, 32'h0000000F);
    commit("ld");
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    pre_check("ld_after");
    check("ld.r7", readData2, 32'h0000000F);
    check("ld.cnt", writeCount, 32'd2);

    // r0 protection
    drive(2'b11, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0, 5'd0);
    pre_check("r0");
    check("r0.wen", {31'd0, regWriteEn}, 32'd0);
    commit("r0");
    check("r0.cnt", writeCount, 32'd2);

    // Preload r3, then a no-write control word must leave it alone
    drive(2'b10, 32'h0, 32'hCAFE0003, 5'd3, 5'd3, 5'd0);
    commit("r3_init");
    drive(2'b01, 32'h12345678, 32'h0, 5'd3, 5'd3, 5'd2);
    pre_check("nowr");
    check("nowr.wdata", writeData, 32'h12345678);
    commit("nowr");
    check("nowr.r3", readData1, 32'hCAFE0003);

    // Reset pulse between edges
    drive(2'b10, 32'h0, 32'hA5A5A5A5, 5'd4, 5'd4, 5'd0);
    commit("r4");
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd4);
    pre_check("r4_after");
    rst = 1'b1;
    clear_model();
    #1;
    check("midrst.r4", readData1, 32'd0);
    check("midrst.cnt", writeCount, 32'd0);
    rst = 1'b0;
    drive(2'b10, 32'h0, 32'h00000042, 5'd9, 5'd9, 5'd4);
    pre_check("post_rst");
    commit("post_rst");
    check("post_rst.cnt", writeCount, 32'd1);

    // Randomized traffic, occasional reset pulse between edges
    for (int n = 0; n < 400; n++) begin
      wr = 5'($urandom_range(0, 31));
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, wr,
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)));
      pre_check("rnd");
      commit("rnd");
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        clear_model();
        #1 rst = 1'b0;
        check("rnd.rst_cnt", writeCount, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
